// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-path definitions.
//   FRAME_LEN_DEF / SAMPLE_W_DEF : default PWM frame length and sample width
//   pwm_dec_state_t              : PWM decoder FSM states
//   sample_t                     : 8-bit PCM sample (shared with the PWM generator)
package audio_pkg;

  localparam int unsigned FRAME_LEN_DEF = 256;
  localparam int unsigned SAMPLE_W_DEF  = 8;

  typedef enum logic [0:0] {
    WAIT,
    MEASURE
  } pwm_dec_state_t;

  typedef logic [7:0] sample_t;

endpackage

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: conditions the asynchronous PWM input pin.
//   clk, reset (async, active-low)
//   pwm_in : raw asynchronous PWM line
//   pin_s  : synchronized (optionally deglitched) line level
//   rise   : one-cycle rising-edge strobe on pin_s
// Build option: PWM_DEGLITCH_EN replaces pin_s with a 2-of-3 majority vote
// over the last three synchronized samples (one extra cycle of latency,
// isolated 1-cycle pulses and dropouts are removed).
module pwm_in_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic pin_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   pin_q, pin_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
    sync_out = sync_q[SYNC_STAGES-1];
  end

`ifdef PWM_DEGLITCH_EN
  // Vote is taken over flop outputs only, so it adds exactly one cycle of lag
  // and preserves the width of any run of two or more cycles.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], sync_out};
    pin_s  = (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= '0;
    else        hist_q <= hist_d;
  end
`else
  always_comb pin_s = sync_out;
`endif

  always_comb begin
    pin_d = pin_s;
    rise  = pin_s & ~pin_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      pin_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      pin_q  <= pin_d;
    end
  end

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers PCM samples from a single-bit PWM audio stream.
// A frame is FRAME_LEN clocks long and starts on a rising edge; the sample is
// (number of high cycles in the frame) - 1, saturated to 0..FRAME_LEN-1.
//   clk, reset (async, active-low)
//   pwm_in       : asynchronous PWM input
//   sample_data  : recovered sample, held in a one-entry output register
//   sample_valid : sample_data holds an unconsumed sample
//   sample_ready : consumer takes the sample when valid && ready
//   overrun      : one-cycle pulse when an unconsumed sample is overwritten
//   frame_err    : one-cycle pulse when a rising edge cuts a frame short
// Build option: PWM_DEGLITCH_EN enables the majority filter in pwm_in_cond.
module pwm_decoder
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = FRAME_LEN_DEF,
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err
);

  localparam int unsigned         HW       = SAMPLE_W + 1;
  localparam logic [SAMPLE_W-1:0] LAST_CYC = SAMPLE_W'(FRAME_LEN - 1);
  localparam logic [SAMPLE_W-1:0] CYC_ONE  = SAMPLE_W'(1);
  localparam logic [HW-1:0]       HI_ONE   = HW'(1);

  logic pin_s;
  logic rise;

  pwm_in_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .pin_s (pin_s),
    .rise  (rise)
  );

  pwm_dec_state_t      state_q, state_d;
  logic [SAMPLE_W-1:0] cyc_q, cyc_d;
  logic [HW-1:0]       hi_q, hi_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                ferr_q, ferr_d;

  logic                emit;
  logic [SAMPLE_W-1:0] emit_val;
  logic [HW-1:0]       hi_total;
  logic [HW-1:0]       hi_m1;

  always_comb begin
    // hi_total counts the current cycle too; at most FRAME_LEN, which fits HW bits.
    hi_total = hi_q + HW'(pin_s);
    hi_m1    = hi_total - HI_ONE;

    state_d  = state_q;
    cyc_d    = cyc_q + CYC_ONE;
    hi_d     = hi_q;
    ferr_d   = 1'b0;
    emit     = 1'b0;
    emit_val = '0;

    case (state_q)
      WAIT: begin
        hi_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cyc_d   = CYC_ONE;
          hi_d    = HI_ONE;
        end else if (cyc_q == LAST_CYC) begin
          // Line idle low for a whole frame: that is sample 0.
          emit  = 1'b1;
          cyc_d = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          ferr_d = 1'b1;
          cyc_d  = CYC_ONE;
          hi_d   = HI_ONE;
        end else if (cyc_q == LAST_CYC) begin
          emit     = 1'b1;
          emit_val = (hi_total == '0) ? '0 : hi_m1[SAMPLE_W-1:0];
          cyc_d    = '0;
          hi_d     = '0;
          // Line still high: the next frame has already begun, no edge will come.
          if (!pin_s) state_d = WAIT;
        end else begin
          hi_d = hi_total;
        end
      end
      default: state_d = WAIT;
    endcase

    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (emit) begin
      data_d    = emit_val;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~sample_ready;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT;
      cyc_q     <= '0;
      hi_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      hi_q      <= hi_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    sample_data  = data_q;
    sample_valid = valid_q;
    overrun      = overrun_q;
    frame_err    = ferr_q;
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed self-checking bench for pwm_decoder.
// Inputs change 1 time unit after a rising clock edge; outputs are observed
// at the same point, so "cycle N" means "just after rising edge N" counted
// from the latest reset release.
module tb_pwm_decoder;

`ifdef PWM_DEGLITCH_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       pwm_in       = 1'b0;
  logic       sample_ready = 1'b0;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       overrun;
  logic       frame_err;

  always #5 clk = ~clk;

  pwm_decoder #(
    .FRAME_LEN  (256),
    .SAMPLE_W   (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    int         at;
  } smp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  smp_t smp_q[$];
  int   fe_q[$];
  int   ov_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p);
    pwm_in = p;
    @(posedge clk);
    #1;
    cyc++;
    if (sample_valid && sample_ready) smp_q.push_back('{data: sample_data, at: cyc});
    if (frame_err) fe_q.push_back(cyc);
    if (overrun) ov_q.push_back(cyc);
  endtask

  // Playback generator: line high while counter <= sample, counter c0..c1-1.
  task automatic gen(input int s, input int c0, input int c1);
    for (int c = c0; c < c1; c++) step(c <= s);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    pwm_in       = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    smp_q.delete();
    fe_q.delete();
    ov_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", sample_data, 8'h00);
    chk("reset_valid", sample_valid, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);

    // Idle-low line: a 0x00 every 256 cycles through the WAIT timeout
    do_reset();
    sample_ready = 1'b1;
    repeat (1000) step(1'b0);
    chk("idle_count", smp_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle_data%0d", k), smp_q[k].data, 8'h00);
      chk($sformatf("idle_at%0d", k), smp_q[k].at, 256 * (k + 1));
    end
    chk("idle_ferr", fe_q.size(), 0);

    // Constant-high line: contiguous 0xFF frames
    do_reset();
    sample_ready = 1'b1;
    repeat (800) step(1'b1);
    chk("high_count", smp_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("high_data%0d", k), smp_q[k].data, 8'hFF);
      chk($sformatf("high_at%0d", k), smp_q[k].at, LAT + 256 * (k + 1));
    end
    chk("high_ferr", fe_q.size(), 0);

`ifndef PWM_DEGLITCH_EN
    // Generator loopback; the 0xFF frame leaves the line high, so the following
    // all-low frame is measured and decodes to 0x00.
    do_reset();
    sample_ready = 1'b1;
    gen(8'h00, 0, 256);
    gen(8'h01, 0, 256);
    gen(8'h7F, 0, 256);
    gen(8'hFE, 0, 256);
    gen(8'hFF, 0, 256);
    repeat (300) step(1'b0);
    chk("loop_count", smp_q.size(), 6);
    chk("loop_data0", smp_q[0].data, 8'h00);
    chk("loop_data1", smp_q[1].data, 8'h01);
    chk("loop_data2", smp_q[2].data, 8'h7F);
    chk("loop_data3", smp_q[3].data, 8'hFE);
    chk("loop_data4", smp_q[4].data, 8'hFF);
    chk("loop_data5", smp_q[5].data, 8'h00);
    for (int k = 0; k < 6; k++) chk($sformatf("loop_at%0d", k), smp_q[k].at, 258 + 256 * k);
    chk("loop_ferr", fe_q.size(), 0);
`endif

    // Rising edges every 100 cycles: frame_err each time after the first, no samples
    do_reset();
    sample_ready = 1'b1;
    for (int c = 0; c < 600; c++) step((c % 100) < 10);
    chk("short_ferr_count", fe_q.size(), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("short_ferr_at%0d", k), fe_q[k], LAT + 1 + 100 * (k + 1));
    chk("short_samples", smp_q.size(), 0);

    // Overrun: 0x40 then 0x80 with ready low
    do_reset();
    gen(8'h40, 0, 256);
    gen(8'h80, 0, 10);
    chk("ovr_first_valid", sample_valid, 1'b1);
    chk("ovr_first_data", sample_data, 8'h40);
    gen(8'h80, 10, 256);
    repeat (20) step(1'b0);
    chk("ovr_count", ov_q.size(), 1);
    chk("ovr_at", ov_q[0], LAT + 512);
    chk("ovr_valid_held", sample_valid, 1'b1);
    chk("ovr_data", sample_data, 8'h80);
    sample_ready = 1'b1;
    step(1'b0);
    chk("ovr_drain_valid", sample_valid, 1'b0);
    chk("ovr_count_after", ov_q.size(), 1);

    // Asynchronous reset at cycle 130 of a 0x90 frame
    do_reset();
    gen(8'h40, 0, 256);
    gen(8'h90, 0, 130);
    chk("mid_pre_valid", sample_valid, 1'b1);
    chk("mid_pre_data", sample_data, 8'h40);
    reset  = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("mid_rst_valid", sample_valid, 1'b0);
    chk("mid_rst_data", sample_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    smp_q.delete();
    fe_q.delete();
    sample_ready = 1'b1;
    gen(8'h90, 0, 256);
    repeat (10) step(1'b0);
    chk("mid_count", smp_q.size(), 1);
    chk("mid_data", smp_q[0].data, 8'h90);
    chk("mid_at", smp_q[0].at, LAT + 256);
    chk("mid_ferr", fe_q.size(), 0);

`ifdef PWM_DEGLITCH_EN
    // One-cycle dropout inside the high part of a 0x90 frame is voted out
    do_reset();
    sample_ready = 1'b1;
    for (int c = 0; c < 256; c++) step((c == 60) ? 1'b0 : (c <= 8'h90));
    repeat (10) step(1'b0);
    chk("glitch_count", smp_q.size(), 1);
    chk("glitch_data", smp_q[0].data, 8'h90);
    chk("glitch_ferr", fe_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
